mem_arb: RTL
============

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter TMO_CYC, default 255: bus wait-state timeout in cycles, range 1..255.
REQ-002 SHALL have port clk input 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst input 1: one clock; reset is asynchronous and active-high.
REQ-004 SHALL have fetch ports hs_if4ma_val input 1 (fetch request), i_if_adr input 32 (fetch address), hs_ma4if_rdy output 1 (fetch done pulse), o_if_rdat output 32 (fetch data), o_if_err output 1 (fetch timeout).
REQ-005 SHALL have load/store ports hs_ls4ma_val input 1, i_ls_adr input 32, i_ls_wdat input 32, i_ls_wen input 4, i_ls_ren input 1, hs_ma4ls_rdy output 1, o_ls_rdat output 32, o_ls_err output 1; these carry the AGU address, lane-aligned write data and byte enables.
REQ-006 SHALL have bus ports o_bus_req output 1, o_bus_adr output 32, o_bus_wdat output 32, o_bus_wen output 4, o_bus_ren output 1, i_bus_ack input 1 (single-cycle completion), i_bus_rdat input 32 (valid with ack).

Function
REQ-007 SHALL share one bus port between fetch and load/store requesters using FSM states IDLE, IF_BUSY, LS_BUSY.
REQ-008 IDLE: with no request, stay IDLE; with one request, grant it; with both, grant per REQ-021.
REQ-009 On grant, SHALL latch address, wdat, wen, ren into bus registers (fetch: wen=0, ren=1, wdat=0) and enter IF_BUSY/LS_BUSY; o_bus_req rises the cycle after the grant decision.
REQ-010 In BUSY, o_bus_req and all o_bus_* SHALL stay stable until the ack cycle; requester inputs changing mid-transaction SHALL be ignored.
REQ-011 On i_bus_ack in BUSY, SHALL register i_bus_rdat (load) into owner's rdat, pulse owner's rdy high exactly one cycle after ack, deassert o_bus_req in that same cycle, and return to IDLE.
REQ-012 Minimum latency: request at cycle N, bus_req at N+1, ack at N+1 gives rdy at N+2; back-to-back grants SHALL have one IDLE cycle between transactions.
REQ-013 Store (wen!=0, ren=0): o_ls_rdat SHALL be 0 on its rdy pulse.
REQ-014 i_bus_ack in IDLE SHALL be ignored and change no state.
REQ-015 SHALL count BUSY cycles in an 8-bit counter cleared on grant; when it reaches TMO_CYC without ack, SHALL drop o_bus_req, pulse owner's rdy with owner's err=1 and rdat=0, and return to IDLE.
REQ-016 Ack in the same cycle the counter reaches TMO_CYC SHALL count as success (err=0).
REQ-017 err outputs SHALL be valid only with their rdy pulse and 0 otherwise; rdat outputs hold last value between pulses.
REQ-018 A requester SHALL never receive rdy without a prior granted val; both rdy outputs SHALL never be high together.

Reset
REQ-019 While rst high: state IDLE, counter 0, o_bus_req 0, o_bus_adr/wdat 0, o_bus_wen 0, o_bus_ren 0, both rdy 0, both err 0, both rdat 0.
REQ-020 Reset asserted mid-transaction SHALL abort it immediately with no rdy pulse; after release, first grant no earlier than the first rising edge with rst low.

Configuration
REQ-021 Macro CIRNO_MEM_ARB_RR_EN: defined -> round-robin, a 1-bit last-owner register (reset to fetch) gives simultaneous-request priority to the requester not granted last; undefined -> fixed priority, load/store always wins simultaneous requests.

Verification
REQ-022 Fetch only: if_val=1, adr=0x100, ack 2 cycles after bus_req with rdat=0x00000013 -> o_bus_ren=1, wen=0, if_rdy one pulse, o_if_rdat=0x00000013, err=0.
REQ-023 Store: ls_val=1, adr=0x204, wdat=0x0000AB00, wen=0b0010, ack 1 cycle -> bus carries exactly those values, ls_rdy one pulse, o_ls_rdat=0.
REQ-024 Both requests held for 4 transactions, ack immediate: RR_EN defined -> grants LS,IF,LS,IF; undefined -> LS,LS,LS,LS while fetch starves.
REQ-025 TMO_CYC=4, no ack -> o_bus_req high 4 cycles then low, ls_rdy pulse with o_ls_err=1, rdat=0; ack at cycle 4 variant -> err=0.
REQ-026 rst pulsed at second BUSY cycle -> o_bus_req 0 immediately, no rdy pulse, late stray ack ignored, next request served normally.

Source files
------------

// File: rtl/mem_arb_if.sv
// Request, response and shared-bus signals between mem_arb and its requesters/bus.
// The arbiter uses the slave modport; the environment drives through master.
interface mem_arb_if;
    logic        hs_if4ma_val;
    logic [31:0] i_if_adr;
    logic        hs_ma4if_rdy;
    logic [31:0] o_if_rdat;
    logic        o_if_err;

    logic        hs_ls4ma_val;
    logic [31:0] i_ls_adr;
    logic [31:0] i_ls_wdat;
    logic [3:0]  i_ls_wen;
    logic        i_ls_ren;
    logic        hs_ma4ls_rdy;
    logic [31:0] o_ls_rdat;
    logic        o_ls_err;

    logic        o_bus_req;
    logic [31:0] o_bus_adr;
    logic [31:0] o_bus_wdat;
    logic [3:0]  o_bus_wen;
    logic        o_bus_ren;
    logic        i_bus_ack;
    logic [31:0] i_bus_rdat;

    modport slave (
        input  hs_if4ma_val, i_if_adr,
        output hs_ma4if_rdy, o_if_rdat, o_if_err,
        input  hs_ls4ma_val, i_ls_adr, i_ls_wdat, i_ls_wen, i_ls_ren,
        output hs_ma4ls_rdy, o_ls_rdat, o_ls_err,
        output o_bus_req, o_bus_adr, o_bus_wdat, o_bus_wen, o_bus_ren,
        input  i_bus_ack, i_bus_rdat
    );

    modport master (
        output hs_if4ma_val, i_if_adr,
        input  hs_ma4if_rdy, o_if_rdat, o_if_err,
        output hs_ls4ma_val, i_ls_adr, i_ls_wdat, i_ls_wen, i_ls_ren,
        input  hs_ma4ls_rdy, o_ls_rdat, o_ls_err,
        input  o_bus_req, o_bus_adr, o_bus_wdat, o_bus_wen, o_bus_ren,
        output i_bus_ack, i_bus_rdat
    );
endinterface

// File: rtl/mem_arb.sv
// Fetch / load-store arbiter sharing one single-ack bus, with a wait-state timeout.
// Define CIRNO_MEM_ARB_RR_EN for round-robin arbitration; otherwise load/store has fixed priority.
module mem_arb #(
    parameter int unsigned TMO_CYC = 255
) (
    input logic      clk,
    input logic      rst,
    mem_arb_if.slave ma
);
    typedef enum logic [1:0] {IDLE, IF_BUSY, LS_BUSY} state_t;

    localparam logic [7:0] TmoLim = 8'(TMO_CYC);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        busReq_q, busReq_d;
    logic [31:0] busAdr_q, busAdr_d;
    logic [31:0] busWdat_q, busWdat_d;
    logic [3:0]  busWen_q, busWen_d;
    logic        busRen_q, busRen_d;
    logic        ifRdy_q, ifRdy_d;
    logic        ifErr_q, ifErr_d;
    logic [31:0] ifRdat_q, ifRdat_d;
    logic        lsRdy_q, lsRdy_d;
    logic        lsErr_q, lsErr_d;
    logic [31:0] lsRdat_q, lsRdat_d;
`ifdef CIRNO_MEM_ARB_RR_EN
    logic        lastLs_q, lastLs_d;
`endif

    logic        grantLs, grantIf;
    logic [7:0]  cntInc;
    logic        done, timeout;
    logic [31:0] rspRdat;

    // Grant decision; only meaningful while the bus is free.
    always_comb begin
        grantLs = 1'b0;
        grantIf = 1'b0;
        if (state_q == IDLE) begin
`ifdef CIRNO_MEM_ARB_RR_EN
            grantLs = ma.hs_ls4ma_val && (!ma.hs_if4ma_val || !lastLs_q);
`else
            grantLs = ma.hs_ls4ma_val;
`endif
            grantIf = ma.hs_if4ma_val && !grantLs;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busReq_d  = busReq_q;
        busAdr_d  = busAdr_q;
        busWdat_d = busWdat_q;
        busWen_d  = busWen_q;
        busRen_d  = busRen_q;
        ifRdy_d   = 1'b0;
        ifErr_d   = 1'b0;
        ifRdat_d  = ifRdat_q;
        lsRdy_d   = 1'b0;
        lsErr_d   = 1'b0;
        lsRdat_d  = lsRdat_q;
`ifdef CIRNO_MEM_ARB_RR_EN
        lastLs_d  = lastLs_q;
`endif
        cntInc    = cnt_q + 8'd1;
        done      = 1'b0;
        timeout   = 1'b0;
        rspRdat   = busRen_q ? ma.i_bus_rdat : 32'd0;

        case (state_q)
            IDLE: begin
                if (grantLs) begin
                    state_d   = LS_BUSY;
                    cnt_d     = 8'd0;
                    busReq_d  = 1'b1;
                    busAdr_d  = ma.i_ls_adr;
                    busWdat_d = ma.i_ls_wdat;
                    busWen_d  = ma.i_ls_wen;
                    busRen_d  = ma.i_ls_ren;
`ifdef CIRNO_MEM_ARB_RR_EN
                    lastLs_d  = 1'b1;
`endif
                end else if (grantIf) begin
                    state_d   = IF_BUSY;
                    cnt_d     = 8'd0;
                    busReq_d  = 1'b1;
                    busAdr_d  = ma.i_if_adr;
                    busWdat_d = 32'd0;
                    busWen_d  = 4'd0;
                    busRen_d  = 1'b1;
`ifdef CIRNO_MEM_ARB_RR_EN
                    lastLs_d  = 1'b0;
`endif
                end
            end
            IF_BUSY, LS_BUSY: begin
                cnt_d = cntInc;
                // An ack landing on the timeout cycle still wins.
                if (ma.i_bus_ack) begin
                    done = 1'b1;
                end else if (cntInc == TmoLim) begin
                    done    = 1'b1;
                    timeout = 1'b1;
                    rspRdat = 32'd0;
                end
                if (done) begin
                    state_d  = IDLE;
                    busReq_d = 1'b0;
                    if (state_q == LS_BUSY) begin
                        lsRdy_d  = 1'b1;
                        lsErr_d  = timeout;
                        lsRdat_d = rspRdat;
                    end else begin
                        ifRdy_d  = 1'b1;
                        ifErr_d  = timeout;
                        ifRdat_d = rspRdat;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                busReq_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            busReq_q  <= 1'b0;
            busAdr_q  <= 32'd0;
            busWdat_q <= 32'd0;
            busWen_q  <= 4'd0;
            busRen_q  <= 1'b0;
            ifRdy_q   <= 1'b0;
            ifErr_q   <= 1'b0;
            ifRdat_q  <= 32'd0;
            lsRdy_q   <= 1'b0;
            lsErr_q   <= 1'b0;
            lsRdat_q  <= 32'd0;
`ifdef CIRNO_MEM_ARB_RR_EN
            lastLs_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busReq_q  <= busReq_d;
            busAdr_q  <= busAdr_d;
            busWdat_q <= busWdat_d;
            busWen_q  <= busWen_d;
            busRen_q  <= busRen_d;
            ifRdy_q   <= ifRdy_d;
            ifErr_q   <= ifErr_d;
            ifRdat_q  <= ifRdat_d;
            lsRdy_q   <= lsRdy_d;
            lsErr_q   <= lsErr_d;
            lsRdat_q  <= lsRdat_d;
`ifdef CIRNO_MEM_ARB_RR_EN
            lastLs_q  <= lastLs_d;
`endif
        end
    end

    assign ma.o_bus_req    = busReq_q;
    assign ma.o_bus_adr    = busAdr_q;
    assign ma.o_bus_wdat   = busWdat_q;
    assign ma.o_bus_wen    = busWen_q;
    assign ma.o_bus_ren    = busRen_q;
    assign ma.hs_ma4if_rdy = ifRdy_q;
    assign ma.o_if_err     = ifErr_q;
    assign ma.o_if_rdat    = ifRdat_q;
    assign ma.hs_ma4ls_rdy = lsRdy_q;
    assign ma.o_ls_err     = lsErr_q;
    assign ma.o_ls_rdat    = lsRdat_q;
endmodule
